// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
//
// Memory-side responder for the cache/memory block-transfer protocol. It holds
// a block-organised backing store and stands in for main memory. Dirty-block
// write-backs arrive over the valid_cache/ready_mem handshake. Refill blocks
// return over the valid_mem/ready_cache handshake after READ_LAT cycles.
// Only one operation is outstanding at a time.
//
// Parameters:
//   ADDR_W    block address width; DEPTH = 2**ADDR_W blocks
//   BLOCK_W   cache block width in bits
//   READ_LAT  cycles from read accept to first valid_mem cycle (1..15)
//   WRITE_LAT busy cycles after a write-back accept (0..15)
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   read_en_mem  in   refill request (level, held until refill completes)
//   write_en_mem in   write-back strobe
//   valid_cache  in   cache presents a write-back block
//   ready_cache  in   cache can accept a refill block
//   addr         in   block address, stable while a request is pending
//   wdata_block  in   write-back data
//   ready_mem    out  responder idle; can accept a write-back or read
//   valid_mem    out  rdata_block holds valid refill data
//   rdata_block  out  registered refill data
// -----------------------------------------------------------------------------
module main_memory_responder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BLOCK_W   = 128,
  parameter int unsigned READ_LAT  = 3,
  parameter int unsigned WRITE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_en_mem,
  input  logic               write_en_mem,
  input  logic               valid_cache,
  input  logic               ready_cache,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata_block,
  output logic               ready_mem,
  output logic               valid_mem,
  output logic [BLOCK_W-1:0] rdata_block
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Counter preload values. The guards keep the unused branch of each
  // latency case from wrapping when the latency sits at its lower limit.
  localparam logic [3:0] WR_LOAD = (WRITE_LAT > 0) ? 4'(WRITE_LAT - 1) : 4'd0;
  localparam logic [3:0] RD_LOAD = (READ_LAT  > 1) ? 4'(READ_LAT  - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_WAIT = 2'd2,
    RD_SEND = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLOCK_W-1:0]  rdata_q;

  logic                wr_acc;
  logic                rd_acc;
  logic                rd_load;
  logic [ADDR_W-1:0]   rd_addr;

  logic [BLOCK_W-1:0]  mem [0:DEPTH-1];

  assign ready_mem   = (state_q == IDLE);
  assign valid_mem   = (state_q == RD_SEND);
  assign rdata_block = rdata_q;

  // A write-back wins over a simultaneous refill request. The refill is picked
  // up on the next IDLE cycle because read_en_mem is a level.
  assign wr_acc = ready_mem && valid_cache && write_en_mem;
  assign rd_acc = ready_mem && read_en_mem && !wr_acc;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    rd_load   = 1'b0;
    rd_addr   = addr_q;

    unique case (state_q)
      IDLE: begin
        if (wr_acc) begin
          if (WRITE_LAT != 0) begin
            state_d   = WR_BUSY;
            lat_cnt_d = WR_LOAD;
          end
        end else if (rd_acc) begin
          addr_d = addr;
          if (READ_LAT == 1) begin
            // The array is read with the live address; addr_q is not valid yet.
            state_d = RD_SEND;
            rd_load = 1'b1;
            rd_addr = addr;
          end else begin
            state_d   = RD_WAIT;
            lat_cnt_d = RD_LOAD;
          end
        end
      end

      WR_BUSY: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      RD_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = RD_SEND;
          rd_load = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      RD_SEND: begin
        if (ready_cache) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      addr_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      if (rd_load) begin
        rdata_q <= mem[rd_addr];
      end
    end
  end

  // NOTE: the backing store has no reset. Contents are undefined at power-up
  // and survive rst_n, so this block is clocked only and maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[addr] <= wdata_block;
    end
  end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Memory-side responder for the cache/memory block-transfer protocol, answering the cache controller's write-back and refill requests. It holds a block-organised backing store and accepts dirty-block write-backs over the valid_cache/ready_mem handshake. It returns refill blocks over the valid_mem/ready_cache handshake after a configurable access latency. It sits between the cache controller/datapath and the top level, standing in for main memory in synthesis and simulation.

## Interface
- ADDR_W, default 8: block address width; DEPTH = 2**ADDR_W blocks, so no address is out of range.
- BLOCK_W, default 128: cache block (line) width in bits.
- READ_LAT, default 3: cycles from read accept to first valid_mem cycle; legal range 1..15.
- WRITE_LAT, default 2: busy cycles after a write-back is accepted; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- read_en_mem  input  1  refill request from the cache; level, held until the refill completes.
- write_en_mem  input  1  write-back strobe from the cache.
- valid_cache  input  1  cache is presenting a write-back block.
- ready_cache  input  1  cache can accept a refill block.
- addr  input  ADDR_W  block address; stable while a request is pending.
- wdata_block  input  BLOCK_W  write-back data.
- ready_mem  output  1  responder can accept a write-back or read request.
- valid_mem  output  1  rdata_block holds valid refill data.
- rdata_block  output  BLOCK_W  refill data, registered.

## Operation
- Storage: DEPTH x BLOCK_W array, not reset. Contents are undefined at power-up and preserved across rst_n.
- FSM states: IDLE, WR_BUSY, RD_WAIT, RD_SEND. A down-counter lat_cnt (4 bits) serves WR_BUSY and RD_WAIT.
- ready_mem = (state == IDLE), decoded combinationally from state only.
- valid_mem = (state == RD_SEND), registered via state.
- Write accept occurs in IDLE when valid_cache && write_en_mem && ready_mem. valid_cache without write_en_mem is not a transfer and causes no write or state change.
- On write accept, mem[addr] <= wdata_block at that edge.
  - WRITE_LAT == 0: stay in IDLE.
  - Otherwise: go to WR_BUSY with lat_cnt = WRITE_LAT-1.
- WR_BUSY: decrement lat_cnt; at lat_cnt == 0, go to IDLE.
- Read accept occurs in IDLE when read_en_mem && no write accept in the same cycle. Write has priority; the read is served once IDLE is re-entered, because read_en_mem is level.
- On read accept, latch addr into addr_q.
  - READ_LAT == 1: go directly to RD_SEND and load rdata_block <= mem[addr].
  - Otherwise: go to RD_WAIT with lat_cnt = READ_LAT-2.
- RD_WAIT: decrement lat_cnt. At lat_cnt == 0, load rdata_block <= mem[addr_q] and go to RD_SEND.
- RD_SEND: hold valid_mem and rdata_block stable until valid_mem && ready_cache, then go to IDLE. rdata_block retains its value afterwards.
- Inputs write_en_mem, valid_cache and wdata_block are ignored outside IDLE. read_en_mem is also ignored outside IDLE.

## Timing
- Reset values (async, immediate): state IDLE, ready_mem 1, valid_mem 0, rdata_block 0, lat_cnt 0, addr_q 0.
- Reset mid-operation: any pending read or busy period is abandoned, and valid_mem drops without completing the handshake. An accepted write already committed stays in the array.
- Write: handshake in cycle T, array updated at end of T. ready_mem is low in cycles T+1..T+WRITE_LAT and high again in T+WRITE_LAT+1.
- Read: accept in cycle T. valid_mem is first high in cycle T+READ_LAT, with data reflecting every write accepted before T.
- Refill completes in the first cycle at or after T+READ_LAT with ready_cache high. ready_mem is high the following cycle.
- Back-to-back operation: a new request can be accepted in the cycle after the responder returns to IDLE. There is no request pipelining; at most one operation is outstanding.
- Simultaneous write and read request in IDLE: the write is accepted. The read is accepted in the first later IDLE cycle and returns the newly written data if the addresses match.

## Test plan
- Reset: hold rst_n low mid-cycle -> immediately ready_mem=1, valid_mem=0, rdata_block=0; release -> IDLE, still ready_mem=1.
- Write then refill (READ_LAT=3, WRITE_LAT=2): write addr 0x05, data 0xA5A5_..._A5 -> ready_mem low exactly 2 cycles. Read 0x05 accepted at T -> valid_mem high at T+3 with 0xA5A5_..._A5, ready_cache=1 -> ready_mem=1 at T+4.
- Backpressure: during RD_SEND hold ready_cache=0 for 4 cycles -> valid_mem=1 and rdata_block constant all 4 cycles; raise ready_cache -> valid_mem=0 next cycle.
- Collision: in IDLE assert write (addr 0x10, data 0x1234) and read_en_mem (addr 0x10) together -> write accepted first; read returns 0x1234 READ_LAT cycles after its later accept.
- Non-transfer: valid_cache=1, write_en_mem=0 at addr 0x20 for 3 cycles -> no state change; a subsequent read of 0x20 returns the prior contents.
- Reset in RD_WAIT: after writing 0x77 to addr 0x03, start a read and pulse rst_n low in RD_WAIT -> valid_mem never asserts; a re-issued read of 0x03 returns 0x77.
